// File: rtl/strat_param_ram_arb_if.sv
// Bus bundle for the strategy parameter store: lookup port from the feed
// decoder, host port from the programming bridge, and parity status.
interface strat_param_ram_arb_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 14
);
   logic                  lk_valid;
   logic [ADDR_W-1:0]     lk_addr;
   logic                  lk_ready;
   logic                  lk_rvalid;
   logic [DATA_W-1:0]     lk_rdata;
   logic                  lk_perr;
   logic                  hst_req;
   logic                  hst_we;
   logic [ADDR_W-1:0]     hst_addr;
   logic [DATA_W-1:0]     hst_wdata;
   logic [DATA_W/8-1:0]   hst_be;
   logic                  hst_gnt;
   logic                  hst_rvalid;
   logic [DATA_W-1:0]     hst_rdata;
   logic                  perr_sticky;

   modport master (
      output lk_valid, lk_addr, hst_req, hst_we, hst_addr, hst_wdata, hst_be,
      input  lk_ready, lk_rvalid, lk_rdata, lk_perr,
             hst_gnt, hst_rvalid, hst_rdata, perr_sticky
   );

   modport slave (
      input  lk_valid, lk_addr, hst_req, hst_we, hst_addr, hst_wdata, hst_be,
      output lk_ready, lk_rvalid, lk_rdata, lk_perr,
             hst_gnt, hst_rvalid, hst_rdata, perr_sticky
   );
endinterface

// File: rtl/strat_param_ram_arb.sv
// Per-symbol strategy parameter store: one single-port RAM shared between
// the lookup path (default priority) and the host path, with a starvation
// counter that forces a pending host access through after HOST_ARB refusals.
// Optional macro STRAT_PARAM_RAM_PARITY_EN adds one even-parity bit per byte,
// lk_perr on lookups and a sticky error flag.
module strat_param_ram_arb #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 14,
   parameter int HOST_ARB = 100
) (
   input  logic                  clk,
   input  logic                  reset_n,
   strat_param_ram_arb_if.slave  bus
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = $clog2(HOST_ARB + 1);
`ifdef STRAT_PARAM_RAM_PARITY_EN
   localparam int MEM_W = DATA_W + NB;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [MEM_W-1:0]  mem [DEPTH];
   logic [MEM_W-1:0]  rd_q;
   logic [MEM_W-1:0]  wr_word;
   logic [CNT_W-1:0]  starve_cnt;
   logic              force_host;
   logic              lk_fire;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic              lk_rvalid_q;
   logic              hst_rvalid_q;
   logic [DATA_W-1:0] lk_hold;
   logic [DATA_W-1:0] hst_hold;

   // Both grants are suppressed in reset so no access (and no write) happens.
   assign force_host  = (starve_cnt >= CNT_W'(HOST_ARB));
   assign bus.lk_ready = reset_n && !force_host;
   assign bus.hst_gnt  = reset_n && bus.hst_req && (!bus.lk_valid || force_host);
   assign lk_fire      = bus.lk_valid && bus.lk_ready;
   assign ram_en       = lk_fire || bus.hst_gnt;
   assign ram_we       = bus.hst_gnt && bus.hst_we;
   assign ram_addr     = bus.hst_gnt ? bus.hst_addr : bus.lk_addr;

   // Count consecutive refused host cycles, saturating at HOST_ARB.
   always_ff @(posedge clk) begin
      if (!reset_n)
         starve_cnt <= '0;
      else if (!bus.hst_req || bus.hst_gnt)
         starve_cnt <= '0;
      else if (starve_cnt < CNT_W'(HOST_ARB))
         starve_cnt <= starve_cnt + 1'b1;
   end

   // Build the stored word: data plus per-byte even parity when enabled.
   always_comb begin
      wr_word = '0;
      wr_word[DATA_W-1:0] = bus.hst_wdata;
`ifdef STRAT_PARAM_RAM_PARITY_EN
      for (int i = 0; i < NB; i++)
         wr_word[DATA_W+i] = ^bus.hst_wdata[i*8 +: 8];
`endif
   end

   // Single-port RAM, read-first, byte-lane writes; not reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.hst_be[i]) begin
               mem[ram_addr][i*8 +: 8] <= wr_word[i*8 +: 8];
`ifdef STRAT_PARAM_RAM_PARITY_EN
               mem[ram_addr][DATA_W+i] <= wr_word[DATA_W+i];
`endif
            end
         end
      end
      if (ram_en)
         rd_q <= mem[ram_addr];
   end

   // Track which path owns the shared read register this cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lk_rvalid_q  <= 1'b0;
         hst_rvalid_q <= 1'b0;
      end else begin
         lk_rvalid_q  <= lk_fire;
         hst_rvalid_q <= bus.hst_gnt && !bus.hst_we;
      end
   end

   // Capture each path's last read so it holds while the other path reads.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lk_hold  <= '0;
         hst_hold <= '0;
      end else begin
         if (lk_rvalid_q)
            lk_hold <= rd_q[DATA_W-1:0];
         if (hst_rvalid_q)
            hst_hold <= rd_q[DATA_W-1:0];
      end
   end

   assign bus.lk_rvalid  = lk_rvalid_q;
   assign bus.lk_rdata   = lk_rvalid_q ? rd_q[DATA_W-1:0] : lk_hold;
   assign bus.hst_rvalid = hst_rvalid_q;
   assign bus.hst_rdata  = hst_rvalid_q ? rd_q[DATA_W-1:0] : hst_hold;

`ifdef STRAT_PARAM_RAM_PARITY_EN
   logic perr_now;
   logic perr_hold;
   logic sticky_q;

   // Any byte whose stored parity disagrees with its data flags an error.
   always_comb begin
      perr_now = 1'b0;
      for (int i = 0; i < NB; i++)
         if ((^rd_q[i*8 +: 8]) != rd_q[DATA_W+i])
            perr_now = 1'b1;
   end

   // Hold the lookup error with its data and accumulate the sticky flag.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perr_hold <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         if (lk_rvalid_q)
            perr_hold <= perr_now;
         sticky_q <= sticky_q | bus.lk_perr;
      end
   end

   assign bus.lk_perr     = lk_rvalid_q ? perr_now : perr_hold;
   assign bus.perr_sticky = sticky_q | bus.lk_perr;
`else
   assign bus.lk_perr     = 1'b0;
   assign bus.perr_sticky = 1'b0;
`endif
endmodule
